event_readout_sequencer: RTL and testbench
==========================================

// Module: event_readout_sequencer
// PURPOSE
//  Sequences one drift-tube event from trigger to FIFO: opens a capture window on a scintillator
//  trigger, then serializes header, per-tube 8-bit hit data and trailer into the 16-bit readout
//  FIFO, then pulses the tube clear. Sits between the Tube capture instances and fifo16x1024.
// PARAMETERS
//  NUM_TUBES   32   tubes serialized per event (1..255)
//  WINDOW      256  clk100 cycles capture_en stays high after trigger (>=1)
//  CLR_CYCLES  11   length of tube_clr pulse (>=1)
//  SKIP_ZERO   0    1: tubes whose data byte is 0 are not written
// PORTS
//  clk100      in   1              system clock, all logic on rising edge
//  rst_n       in   1              asynchronous active-low reset
//  trig        in   1              scintillator coincidence, synchronous level
//  tube_data   in   NUM_TUBES*8    tube i data at [8i+7:8i], stable while state=TUBES
//  fifo_full   in   1              readout FIFO full
//  capture_en  out  1              gate for tube capture clock/enables
//  tube_clr    out  1              clear to all tube capture blocks
//  fifo_din    out  16             FIFO write data
//  fifo_wr_en  out  1              FIFO write strobe, one word per high cycle
//  busy        out  1              high in any state except IDLE
//  evt_cnt     out  8              completed events, wraps 255->0
//  drop_cnt    out  8              triggers ignored while busy, saturates at 255
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; evt_cnt=drop_cnt=0; tube index 0.
//  - Trigger = rising edge of trig (registered trig_d; edge = trig & ~trig_d).
//  - States: IDLE -> WINDOW -> HEADER -> TUBES -> TRAILER -> CLEAR -> IDLE.
//  - IDLE: on edge go WINDOW next cycle; window counter loaded 0.
//  - WINDOW: capture_en=1; counter++; after WINDOW cycles in state -> HEADER, capture_en=0.
//  - HEADER: write {8'hA5, evt_cnt} -> TUBES with index 0.
//  - TUBES: word i = {tube_data[8i+7:8i], i[7:0]}; one word per cycle when written;
//    SKIP_ZERO=1 and byte==0: no write, index++ in that cycle; after index NUM_TUBES-1 -> TRAILER.
//  - TRAILER: write 16'hFFFF; then evt_cnt++ and -> CLEAR.
//  - CLEAR: tube_clr=1 for exactly CLR_CYCLES cycles, then IDLE (tube_clr=0 on return).
//  - Write handshake: fifo_din/fifo_wr_en registered; fifo_wr_en=1 only if fifo_full=0 in the
//    cycle the word is issued; if fifo_full=1 the state/index hold and the same word is retried
//    each cycle until fifo_full=0. No word is ever dropped or duplicated.
//  - fifo_din holds last written word when fifo_wr_en=0 (no requirement on value, no X).
//  - Trigger edge in any state other than IDLE: ignored, drop_cnt++ (saturating).
//  - Trigger edge on same cycle CLEAR finishes: counted as drop; no event started.
//  - trig held high: only one event (edge-based); new event needs trig low then high.
//  - rst_n low mid-event: immediate return to IDLE, outputs 0; partial event stays in FIFO
//    (no trailer); downstream resyncs on next 0xA5 header.
//  - Latency, no stalls, SKIP_ZERO=0: trigger edge to first header write = WINDOW+2 cycles;
//    event total = WINDOW + NUM_TUBES + 2 writes + CLR_CYCLES + overhead (<=4 cycles).
// TESTING
//  1 Reset: rst_n=0 with trig toggling -> all outputs 0, evt_cnt=drop_cnt=0.
//  2 Single event, defaults, tube i data=i+1, fifo_full=0 -> 34 writes: 0xA500, 0x0100..0x201F,
//    0xFFFF; capture_en high 256 cycles; tube_clr high 11 cycles; evt_cnt=1.
//  3 fifo_full=1 for 20 cycles mid-TUBES at index 5 -> no writes during stall, index 5 word
//    written once after release, total still 34 words in order.
//  4 Second trig edge 100 cycles into WINDOW and one in CLEAR -> drop_cnt=2, exactly one event.
//  5 SKIP_ZERO=1, only tubes 3 and 30 nonzero -> writes 0xA5nn, {d3,0x03}, {d30,0x1E}, 0xFFFF.
//  6 rst_n pulsed low at index 10 -> outputs 0 in reset, next trigger yields full normal event.

Source files
------------

// File: rtl/event_readout_sequencer.sv
// Trigger-to-FIFO sequencer for one drift-tube event: capture window, then header,
// per-tube words and trailer written with full-stall retry, then a tube clear pulse.
module event_readout_sequencer #(
  parameter int NUM_TUBES  = 32,
  parameter int WINDOW     = 256,
  parameter int CLR_CYCLES = 11,
  parameter bit SKIP_ZERO  = 1'b0
) (
  input  logic                   clk100_i,
  input  logic                   rst_n_i,
  input  logic                   trig_i,
  input  logic [NUM_TUBES*8-1:0] tube_data_i,
  input  logic                   fifo_full_i,
  output logic                   capture_en_o,
  output logic                   tube_clr_o,
  output logic [15:0]            fifo_din_o,
  output logic                   fifo_wr_en_o,
  output logic                   busy_o,
  output logic [7:0]             evt_cnt_o,
  output logic [7:0]             drop_cnt_o
);

  localparam int CMAX = (WINDOW > CLR_CYCLES) ? WINDOW : CLR_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WINDOW,
    S_HEADER,
    S_TUBES,
    S_TRAILER,
    S_CLEAR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      idx_q, idx_d;
  logic            trig_q;
  logic [7:0]      evt_q, evt_d;
  logic [7:0]      drop_q, drop_d;
  logic [15:0]     din_q, din_d;
  logic            wr_q, wr_d;
  logic            trig_edge;
  logic [7:0]      tube_byte;
  logic            advance;

  assign trig_edge = trig_i & ~trig_q;

  always_comb begin
    tube_byte = 8'd0;
    for (int i = 0; i < NUM_TUBES; i++) begin
      if (idx_q == 8'(i)) tube_byte = tube_data_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk100_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 8'd0;
      trig_q  <= 1'b0;
      evt_q   <= 8'd0;
      drop_q  <= 8'd0;
      din_q   <= 16'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      trig_q  <= trig_i;
      evt_q   <= evt_d;
      drop_q  <= drop_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    evt_d   = evt_q;
    drop_d  = drop_q;
    din_d   = din_q;
    wr_d    = 1'b0;
    advance = 1'b0;

    // Includes an edge on the final CLEAR cycle: the event ends, the trigger is lost.
    if (trig_edge && (state_q != S_IDLE) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (trig_edge) begin
          state_d = S_WINDOW;
          cnt_d   = '0;
        end
      end
      S_WINDOW: begin
        if (cnt_q == CW'(WINDOW - 1)) state_d = S_HEADER;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      S_HEADER: begin
        if (!fifo_full_i) begin
          wr_d    = 1'b1;
          din_d   = {8'hA5, evt_q};
          idx_d   = 8'd0;
          state_d = S_TUBES;
        end
      end
      S_TUBES: begin
        if (SKIP_ZERO && (tube_byte == 8'd0)) begin
          advance = 1'b1;
        end else if (!fifo_full_i) begin
          wr_d    = 1'b1;
          din_d   = {tube_byte, idx_q};
          advance = 1'b1;
        end
        if (advance) begin
          if (idx_q == 8'(NUM_TUBES - 1)) state_d = S_TRAILER;
          else                            idx_d   = idx_q + 8'd1;
        end
      end
      S_TRAILER: begin
        if (!fifo_full_i) begin
          wr_d    = 1'b1;
          din_d   = 16'hFFFF;
          evt_d   = evt_q + 8'd1;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CW'(CLR_CYCLES - 1)) state_d = S_IDLE;
        else                              cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign capture_en_o = (state_q == S_WINDOW);
  assign tube_clr_o   = (state_q == S_CLEAR);
  assign busy_o       = (state_q != S_IDLE);
  assign fifo_din_o   = din_q;
  assign fifo_wr_en_o = wr_q;
  assign evt_cnt_o    = evt_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_event_readout_sequencer.sv
// Bench for event_readout_sequencer: table of events with an expected-word scoreboard,
// plus hand sequences for reset, mid-event reset and SKIP_ZERO.
module tb_event_readout_sequencer;
  localparam int NT   = 32;
  localparam int WIN  = 256;
  localparam int CLR  = 11;
  localparam int WIN2 = 8;
  localparam int CLR2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, trig, full;
  logic [NT*8-1:0] data;
  logic cap, tclr, wr, busy;
  logic [15:0] din;
  logic [7:0] evt, drop;

  logic trig2, full2;
  logic [NT*8-1:0] data2;
  logic cap2, tclr2, wr2, busy2;
  logic [15:0] din2;
  logic [7:0] evt2, drop2;

  event_readout_sequencer #(.NUM_TUBES(NT), .WINDOW(WIN), .CLR_CYCLES(CLR), .SKIP_ZERO(1'b0)) dut (
    .clk100_i(clk), .rst_n_i(rst_n), .trig_i(trig), .tube_data_i(data), .fifo_full_i(full),
    .capture_en_o(cap), .tube_clr_o(tclr), .fifo_din_o(din), .fifo_wr_en_o(wr),
    .busy_o(busy), .evt_cnt_o(evt), .drop_cnt_o(drop));

  event_readout_sequencer #(.NUM_TUBES(NT), .WINDOW(WIN2), .CLR_CYCLES(CLR2), .SKIP_ZERO(1'b1)) dut_sz (
    .clk100_i(clk), .rst_n_i(rst_n), .trig_i(trig2), .tube_data_i(data2), .fifo_full_i(full2),
    .capture_en_o(cap2), .tube_clr_o(tclr2), .fifo_din_o(din2), .fifo_wr_en_o(wr2),
    .busy_o(busy2), .evt_cnt_o(evt2), .drop_cnt_o(drop2));

  typedef struct {
    int mult;
    int add;
    int stall_idx;
    int stall_len;
    int win_trig_at;
    int clr_trig_at;
    bit hold;
    int exp_evt;
    int exp_drop;
  } vec_t;

  vec_t vecs[5];
  logic [15:0] sb_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_data(input int mult, input int add);
    for (int i = 0; i < NT; i++) data[8*i +: 8] = 8'(i * mult + add);
  endtask

  task automatic push_event(input int hdr_evt);
    sb_q.push_back({8'hA5, 8'(hdr_evt)});
    for (int i = 0; i < NT; i++) sb_q.push_back({data[8*i +: 8], 8'(i)});
    sb_q.push_back(16'hFFFF);
  endtask

  task automatic sb_compare(input string name);
    logic [15:0] w;
    if (sb_q.size() == 0) begin
      check({name, "_extra_word"}, {16'd0, din}, 32'hFFFF_FFFF);
    end else begin
      w = sb_q.pop_front();
      check(name, {16'd0, din}, {16'd0, w});
    end
  endtask

  task automatic run_event(input vec_t v);
    int cap_n = 0, clr_n = 0, words = 0, first = -1, stall_left = 0, stall_bad = 0, idle_busy = 0;
    bit stalled = 0, done = 0, pulse = 0;
    fill_data(v.mult, v.add);
    push_event(v.exp_evt - 1);
    @(negedge clk);
    trig  = 1'b1;
    pulse = !v.hold;
    for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
      @(negedge clk); #1;
      if (pulse) begin trig = 1'b0; pulse = 0; end
      if (cap)  cap_n++;
      if (tclr) clr_n++;
      if (wr) begin
        if (first < 0) first = cyc;
        words++;
        sb_compare("sb_word");
      end
      if (stall_left > 0) begin
        if (wr) stall_bad++;
        stall_left--;
        if (stall_left == 0) full = 1'b0;
      end else if (!stalled && v.stall_len > 0 && words == v.stall_idx + 1) begin
        full = 1'b1;
        stall_left = v.stall_len;
        stalled = 1;
      end
      if (v.win_trig_at > 0 && cap && cap_n == v.win_trig_at) begin trig = 1'b1; pulse = 1; end
      if (v.clr_trig_at > 0 && tclr && clr_n == v.clr_trig_at) begin trig = 1'b1; pulse = 1; end
      if (!busy) done = 1;
    end
    check("event_timeout", {31'd0, done}, 32'd1);
    check("capture_en_cycles", cap_n, WIN);
    check("tube_clr_cycles", clr_n, CLR);
    check("word_count", words, NT + 2);
    check("first_write_latency", first, WIN + 2);
    check("evt_cnt", {24'd0, evt}, v.exp_evt);
    check("drop_cnt", {24'd0, drop}, v.exp_drop);
    check("sb_leftover", sb_q.size(), 0);
    if (v.stall_len > 0) begin
      check("stall_applied", {31'd0, stalled}, 32'd1);
      check("writes_during_stall", stall_bad, 0);
    end
    repeat (20) begin
      @(negedge clk); #1;
      if (busy) idle_busy++;
    end
    check("no_extra_event", idle_busy, 0);
    trig = 1'b0;
    full = 1'b0;
    sb_q.delete();
  endtask

  task automatic run_skip_zero();
    logic [15:0] q2[$];
    logic [15:0] w;
    int words = 0, cap_n = 0, clr_n = 0, first = -1;
    bit done = 0;
    data2 = '0;
    data2[3*8 +: 8]  = 8'h5A;
    data2[30*8 +: 8] = 8'hC3;
    q2.push_back(16'hA500);
    q2.push_back(16'h5A03);
    q2.push_back(16'hC31E);
    q2.push_back(16'hFFFF);
    @(negedge clk);
    trig2 = 1'b1;
    for (int cyc = 1; cyc <= 500 && !done; cyc++) begin
      @(negedge clk); #1;
      trig2 = 1'b0;
      if (cap2)  cap_n++;
      if (tclr2) clr_n++;
      if (wr2) begin
        if (first < 0) first = cyc;
        words++;
        if (q2.size() == 0) begin
          check("sz_extra_word", {16'd0, din2}, 32'hFFFF_FFFF);
        end else begin
          w = q2.pop_front();
          check("sz_word", {16'd0, din2}, {16'd0, w});
        end
      end
      if (!busy2) done = 1;
    end
    check("sz_timeout", {31'd0, done}, 32'd1);
    check("sz_word_count", words, 4);
    check("sz_first_latency", first, WIN2 + 2);
    check("sz_capture_cycles", cap_n, WIN2);
    check("sz_clr_cycles", clr_n, CLR2);
    check("sz_evt_cnt", {24'd0, evt2}, 32'd1);
    check("sz_leftover", q2.size(), 0);
  endtask

  initial begin
    int words;
    bit hit;
    rst_n = 1'b0; trig = 1'b0; full = 1'b0; data = '0;
    trig2 = 1'b0; full2 = 1'b0; data2 = '0;

    vecs[0] = '{1, 1,   0,  0,   0,  0, 1'b0, 1, 0};
    vecs[1] = '{3, 7,   5, 20,   0,  0, 1'b0, 2, 0};
    vecs[2] = '{7, 9,   0,  0, 100,  5, 1'b0, 3, 2};
    vecs[3] = '{5, 0,   0,  0,   0, 11, 1'b0, 4, 3};
    vecs[4] = '{1, 128, 0,  0,   0,  0, 1'b1, 5, 3};

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      trig = ~trig;
      trig2 = ~trig2;
    end
    #1;
    check("rst_ctrl", {28'd0, cap, tclr, wr, busy}, 32'd0);
    check("rst_din", {16'd0, din}, 32'd0);
    check("rst_cnts", {16'd0, evt, drop}, 32'd0);
    check("rst_sz_outputs", {12'd0, cap2, tclr2, wr2, busy2, din2}, 32'd0);
    @(negedge clk);
    trig = 1'b0; trig2 = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 5; k++) run_event(vecs[k]);

    // Reset while the index-10 word is being issued, then a clean event.
    fill_data(1, 1);
    push_event(5);
    @(negedge clk);
    trig = 1'b1;
    words = 0;
    hit = 0;
    for (int cyc = 1; cyc <= 1000 && !hit; cyc++) begin
      @(negedge clk); #1;
      trig = 1'b0;
      if (wr) begin
        words++;
        sb_compare("partial_word");
      end
      if (words == 11) hit = 1;
    end
    check("partial_reached_idx10", {31'd0, hit}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {28'd0, cap, tclr, wr, busy}, 32'd0);
    check("midrst_din", {16'd0, din}, 32'd0);
    check("midrst_cnts", {16'd0, evt, drop}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    run_event('{1, 1, 0, 0, 0, 0, 1'b0, 1, 0});

    run_skip_zero();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
